// File: rtl/axi_common.sv
// Shared AXI-Lite field types used by every AXI-Lite block in this slice.
package axi_common;

  typedef logic [2:0] prot_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite bundle carrying all five channels; master drives requests, slave drives responses.
interface axi_lite_channel
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0]   aw_addr;
  prot_t                   aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  resp_t                   b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  prot_t                   ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );

endinterface

// File: rtl/axi_fifo.sv
// Generic valid/ready FIFO with registered in_ready/out_valid; DEPTH = 0 degenerates to wires.
module axi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH < 0) begin : g_bad_depth
    $fatal(1, "axi_fifo: DEPTH must not be negative");
  end else if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
  end else begin : g_fifo
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
      count_next = count;
      if (push && !pop) begin
        count_next = count + CW'(1);
      end else if (pop && !push) begin
        count_next = count - CW'(1);
      end
    end

    // Flags come from the next count so neither side sees a combinational path from the other.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        in_ready  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        count     <= count_next;
        in_ready  <= (count_next < FULL);
        out_valid <= (count_next != '0);
        if (push) begin
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= in_data;
      end
    end

    assign out_data = mem[rd_ptr];
  end

endmodule

// File: rtl/axi_lite_buffer.sv
// AXI-Lite buffering hop: one independently sized FIFO (or pass-through) per channel.
module axi_lite_buffer
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int AR_DEPTH   = 2,
  parameter int R_DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  axi_lite_channel.slave  slave,
  axi_lite_channel.master master
);

  localparam int PROT_W = $bits(prot_t);
  localparam int RESP_W = $bits(resp_t);
  localparam int AW_W   = ADDR_WIDTH + PROT_W;
  localparam int W_W    = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int B_W    = RESP_W;
  localparam int AR_W   = ADDR_WIDTH + PROT_W;
  localparam int R_W    = DATA_WIDTH + RESP_W;

  if ($bits(slave.aw_addr) != ADDR_WIDTH || $bits(master.aw_addr) != ADDR_WIDTH ||
      $bits(slave.w_data) != DATA_WIDTH || $bits(master.w_data) != DATA_WIDTH) begin : g_width_check
    $fatal(1, "axi_lite_buffer: interface widths do not match ADDR_WIDTH/DATA_WIDTH");
  end

  if (AW_DEPTH < 0 || W_DEPTH < 0 || B_DEPTH < 0 || AR_DEPTH < 0 || R_DEPTH < 0) begin : g_depth_check
    $fatal(1, "axi_lite_buffer: channel depths must not be negative");
  end

  logic [AW_W-1:0] aw_in;
  logic [AW_W-1:0] aw_out;
  logic [W_W-1:0]  w_in;
  logic [W_W-1:0]  w_out;
  logic [B_W-1:0]  b_in;
  logic [B_W-1:0]  b_out;
  logic [AR_W-1:0] ar_in;
  logic [AR_W-1:0] ar_out;
  logic [R_W-1:0]  r_in;
  logic [R_W-1:0]  r_out;

  assign aw_in           = {slave.aw_addr, slave.aw_prot};
  assign master.aw_addr  = aw_out[AW_W-1:PROT_W];
  assign master.aw_prot  = aw_out[PROT_W-1:0];

  assign w_in            = {slave.w_data, slave.w_strb};
  assign master.w_data   = w_out[W_W-1:DATA_WIDTH/8];
  assign master.w_strb   = w_out[DATA_WIDTH/8-1:0];

  assign ar_in           = {slave.ar_addr, slave.ar_prot};
  assign master.ar_addr  = ar_out[AR_W-1:PROT_W];
  assign master.ar_prot  = ar_out[PROT_W-1:0];

  // Response channels flow the other way: downstream pushes, upstream pops.
  assign b_in            = master.b_resp;
  assign slave.b_resp    = resp_t'(b_out);

  assign r_in            = {master.r_data, master.r_resp};
  assign slave.r_data    = r_out[R_W-1:RESP_W];
  assign slave.r_resp    = resp_t'(r_out[RESP_W-1:0]);

  axi_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (slave.aw_valid),
    .in_ready  (slave.aw_ready),
    .in_data   (aw_in),
    .out_valid (master.aw_valid),
    .out_ready (master.aw_ready),
    .out_data  (aw_out)
  );

  axi_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (slave.w_valid),
    .in_ready  (slave.w_ready),
    .in_data   (w_in),
    .out_valid (master.w_valid),
    .out_ready (master.w_ready),
    .out_data  (w_out)
  );

  axi_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (master.b_valid),
    .in_ready  (master.b_ready),
    .in_data   (b_in),
    .out_valid (slave.b_valid),
    .out_ready (slave.b_ready),
    .out_data  (b_out)
  );

  axi_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (slave.ar_valid),
    .in_ready  (slave.ar_ready),
    .in_data   (ar_in),
    .out_valid (master.ar_valid),
    .out_ready (master.ar_ready),
    .out_data  (ar_out)
  );

  axi_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (master.r_valid),
    .in_ready  (master.r_ready),
    .in_data   (r_in),
    .out_valid (slave.r_valid),
    .out_ready (slave.r_ready),
    .out_data  (r_out)
  );

endmodule

// File: tb/tb_axi_lite_buffer.sv
// Bench for axi_lite_buffer with AW=2, W=3, B=0 (pass-through), AR=2, R=1 entries.
module tb_axi_lite_buffer;
  import axi_common::*;

  localparam int AW = 48;
  localparam int DW = 64;
  localparam int DEPTHS [4] = '{2, 3, 2, 1};

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;
  bit   live = 1'b0;

  // Per buffered channel (0 AW, 1 W, 2 AR, 3 R): beats accepted but not yet delivered, oldest first.
  logic [127:0] model_q [4][$];

  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up ();
  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn ();

  axi_lite_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AW_DEPTH   (2),
    .W_DEPTH    (3),
    .B_DEPTH    (0),
    .AR_DEPTH   (2),
    .R_DEPTH    (1)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .slave  (up.slave),
    .master (dn.master)
  );

  always #5 clk = ~clk;

  function automatic string chan_name(int c);
    case (c)
      0:       return "aw";
      1:       return "w";
      2:       return "ar";
      default: return "r";
    endcase
  endfunction

  function void check_output(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Occupancy after the last edge fixes every flag; the head of the queue fixes the payload.
  always @(negedge clk) begin
    logic [3:0]   iv;
    logic [3:0]   ir;
    logic [3:0]   ov;
    logic [3:0]   orr;
    logic [127:0] id [4];
    logic [127:0] od [4];
    iv  = {dn.r_valid, up.ar_valid, up.w_valid, up.aw_valid};
    ir  = {dn.r_ready, up.ar_ready, up.w_ready, up.aw_ready};
    ov  = {up.r_valid, dn.ar_valid, dn.w_valid, dn.aw_valid};
    orr = {up.r_ready, dn.ar_ready, dn.w_ready, dn.aw_ready};
    id[0] = 128'({up.aw_addr, up.aw_prot});
    od[0] = 128'({dn.aw_addr, dn.aw_prot});
    id[1] = 128'({up.w_data, up.w_strb});
    od[1] = 128'({dn.w_data, dn.w_strb});
    id[2] = 128'({up.ar_addr, up.ar_prot});
    od[2] = 128'({dn.ar_addr, dn.ar_prot});
    id[3] = 128'({dn.r_data, dn.r_resp});
    od[3] = 128'({up.r_data, up.r_resp});
    for (int c = 0; c < 4; c++) begin
      if (!rstn || !live) begin
        check_output({chan_name(c), " in_ready idle"}, 128'(ir[c]), 128'(0));
        check_output({chan_name(c), " out_valid idle"}, 128'(ov[c]), 128'(0));
        if (!rstn) model_q[c].delete();
      end else begin
        check_output({chan_name(c), " in_ready"}, 128'(ir[c]), 128'(model_q[c].size() < DEPTHS[c]));
        check_output({chan_name(c), " out_valid"}, 128'(ov[c]), 128'(model_q[c].size() > 0));
        if (ov[c] && model_q[c].size() > 0) begin
          check_output({chan_name(c), " payload"}, od[c], model_q[c][0]);
          if (orr[c]) void'(model_q[c].pop_front());
        end
        if (iv[c] && ir[c]) model_q[c].push_back(id[c]);
      end
    end
    check_output("b_valid through", 128'(up.b_valid), 128'(dn.b_valid));
    check_output("b_ready through", 128'(dn.b_ready), 128'(up.b_ready));
    check_output("b_resp through", 128'(up.b_resp), 128'(dn.b_resp));
    live = rstn;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up.aw_valid = 1'b0; up.aw_addr = '0; up.aw_prot = '0;
    up.w_valid  = 1'b0; up.w_data  = '0; up.w_strb  = '0;
    up.ar_valid = 1'b0; up.ar_addr = '0; up.ar_prot = '0;
    up.b_ready  = 1'b1; up.r_ready = 1'b1;
    dn.aw_ready = 1'b1; dn.w_ready = 1'b1; dn.ar_ready = 1'b1;
    dn.b_valid  = 1'b0; dn.b_resp  = RESP_OKAY;
    dn.r_valid  = 1'b0; dn.r_data  = '0; dn.r_resp = RESP_OKAY;
  endtask

  task automatic apply_stimulus();
    up.aw_valid = ($urandom_range(0, 3) != 0);
    up.aw_addr  = 48'({$urandom(), $urandom()});
    up.aw_prot  = 3'($urandom());
    up.w_valid  = ($urandom_range(0, 3) != 0);
    up.w_data   = {$urandom(), $urandom()};
    up.w_strb   = 8'($urandom());
    up.ar_valid = ($urandom_range(0, 2) != 0);
    up.ar_addr  = 48'({$urandom(), $urandom()});
    up.ar_prot  = 3'($urandom());
    up.b_ready  = ($urandom_range(0, 1) != 0);
    up.r_ready  = ($urandom_range(0, 3) != 0);
    dn.aw_ready = ($urandom_range(0, 2) != 0);
    dn.w_ready  = ($urandom_range(0, 3) != 0);
    dn.ar_ready = ($urandom_range(0, 1) != 0);
    dn.b_valid  = ($urandom_range(0, 1) != 0);
    dn.b_resp   = resp_t'($urandom_range(0, 3));
    dn.r_valid  = ($urandom_range(0, 3) != 0);
    dn.r_data   = {$urandom(), $urandom()};
    dn.r_resp   = resp_t'($urandom_range(0, 3));
  endtask

  task automatic directed_aw();
    dn.aw_ready = 1'b0;
    up.aw_valid = 1'b1; up.aw_addr = 48'h1000; up.aw_prot = 3'd1;
    next_cycle();
    up.aw_addr = 48'h2000; up.aw_prot = 3'd2;
    next_cycle();
    up.aw_addr = 48'h3000; up.aw_prot = 3'd3;
    @(negedge clk);
    check_output("aw_ready at full", 128'(up.aw_ready), 128'(0));
    next_cycle();
    dn.aw_ready = 1'b1;
    @(negedge clk);
    check_output("aw first addr", 128'(dn.aw_addr), 128'h1000);
    check_output("aw first prot", 128'(dn.aw_prot), 128'd1);
    next_cycle();
    @(negedge clk);
    check_output("aw second addr", 128'(dn.aw_addr), 128'h2000);
    check_output("aw second prot", 128'(dn.aw_prot), 128'd2);
    check_output("aw_ready after pop", 128'(up.aw_ready), 128'(1));
    next_cycle();
    up.aw_valid = 1'b0;
    @(negedge clk);
    check_output("aw third addr", 128'(dn.aw_addr), 128'h3000);
    check_output("aw third prot", 128'(dn.aw_prot), 128'd3);
    next_cycle();
  endtask

  task automatic directed_w();
    dn.w_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      up.w_valid = (i < 16);
      up.w_data  = 64'(i);
      up.w_strb  = 8'hFF;
      @(negedge clk);
      if (i >= 1) begin
        check_output("w stream valid", 128'(dn.w_valid), 128'(1));
        check_output("w stream data", 128'(dn.w_data), 128'(i - 1));
        check_output("w stream strb", 128'(dn.w_strb), 128'hFF);
      end
      next_cycle();
    end
    up.w_valid = 1'b0;
  endtask

  // Beat j enters at the end of cycle 2j and leaves in cycle 2j+1; the source moves on once accepted.
  task automatic directed_r();
    up.r_ready = 1'b1;
    dn.r_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      dn.r_data = 64'((k + 1) / 2);
      dn.r_resp = (((k + 1) / 2) % 2 != 0) ? RESP_SLVERR : RESP_OKAY;
      @(negedge clk);
      check_output("r_valid toggle", 128'(up.r_valid), 128'(k % 2));
      check_output("r_ready toggle", 128'(dn.r_ready), 128'((k + 1) % 2));
      if (k % 2 == 1) begin
        check_output("r beat data", 128'(up.r_data), 128'((k - 1) / 2));
        check_output("r beat resp", 128'(up.r_resp),
                     ((((k - 1) / 2) % 2) != 0) ? 128'(RESP_SLVERR) : 128'(RESP_OKAY));
      end
      next_cycle();
    end
    dn.r_valid = 1'b0;
    next_cycle();
  endtask

  task automatic directed_b();
    dn.b_valid = 1'b1; dn.b_resp = RESP_DECERR; up.b_ready = 1'b0;
    #1;
    check_output("b_valid zero latency", 128'(up.b_valid), 128'(1));
    check_output("b_resp DECERR", 128'(up.b_resp), 128'(RESP_DECERR));
    check_output("b_ready low", 128'(dn.b_ready), 128'(0));
    up.b_ready = 1'b1;
    #1;
    check_output("b_ready high", 128'(dn.b_ready), 128'(1));
    dn.b_valid = 1'b0;
    #1;
    check_output("b_valid drop", 128'(up.b_valid), 128'(0));
    next_cycle();
  endtask

  task automatic directed_ar_reset();
    dn.ar_ready = 1'b0;
    up.ar_valid = 1'b1; up.ar_addr = 48'hA0; up.ar_prot = 3'd0;
    next_cycle();
    up.ar_addr = 48'hB0;
    next_cycle();
    up.ar_valid = 1'b0;
    #1;
    check_output("ar held before reset", 128'(dn.ar_valid), 128'(1));
    check_output("ar head before reset", 128'(dn.ar_addr), 128'hA0);
    rstn = 1'b0;
    #1;
    check_output("ar_valid async drop", 128'(dn.ar_valid), 128'(0));
    check_output("ar_ready in reset", 128'(up.ar_ready), 128'(0));
    check_output("aw_ready async drop", 128'(up.aw_ready), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    dn.ar_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("no stale ar beat", 128'(dn.ar_valid), 128'(0));
      next_cycle();
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_output("aw_ready before first edge", 128'(up.aw_ready), 128'(0));
    next_cycle();
    check_output("aw_ready after first edge", 128'(up.aw_ready), 128'(1));
    check_output("w_ready after first edge", 128'(up.w_ready), 128'(1));
    check_output("ar_ready after first edge", 128'(up.ar_ready), 128'(1));
    check_output("r_ready after first edge", 128'(dn.r_ready), 128'(1));

    directed_aw();
    directed_w();
    directed_r();
    directed_b();
    directed_ar_reset();

    for (int n = 0; n < 2000; n++) begin
      apply_stimulus();
      if (n == 1000) rstn = 1'b0;
      if (n == 1003) rstn = 1'b1;
      next_cycle();
    end
    idle_inputs();
    repeat (8) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_buffer.md
# axi_lite_buffer

Parametrised AXI-Lite buffering stage placed between an upstream AXI-Lite master and a downstream slave (interconnect hop, clock-tree break, timing cut). Each of the five channels (AW, W, B, AR, R) gets an independently sized FIFO or a zero-cost pass-through, selected per channel by a depth parameter. Payload is forwarded unmodified and in order; only timing and elasticity change.

## Interface
Parameters:
- ADDR_WIDTH, 48, address width; must equal both attached interfaces' ADDR_WIDTH.
- DATA_WIDTH, 64, data width; must equal both attached interfaces' DATA_WIDTH.
- AW_DEPTH, 2, AW FIFO entries; 0 = pass-through.
- W_DEPTH, 2, W FIFO entries; 0 = pass-through.
- B_DEPTH, 2, B FIFO entries; 0 = pass-through.
- AR_DEPTH, 2, AR FIFO entries; 0 = pass-through.
- R_DEPTH, 2, R FIFO entries; 0 = pass-through.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- slave  axi_lite_channel.slave  interface  upstream side; AW/W/AR flow in, B/R flow out.
- master  axi_lite_channel.master  interface  downstream side; AW/W/AR flow out, B/R flow in.

## Operation
- Request channels (AW, W, AR) push from `slave`, pop to `master`; response channels (B, R) push from `master`, pop to `slave`.
- Payloads: AW = {aw_addr, aw_prot}, W = {w_data, w_strb}, B = {b_resp}, AR = {ar_addr, ar_prot}, R = {r_data, r_resp}.
- DEPTH = 0: valid, ready and payload wired straight through; no state, no latency.
- DEPTH ≥ 1: circular FIFO; read/write pointers wrap at DEPTH (need not be a power of 2); occupancy counter width $clog2(DEPTH+1).
- Push when in_valid && in_ready; pop when out_valid && out_ready; push and pop in the same cycle leave count unchanged.
- in_ready and out_valid are registered (driven from next-state count), so no combinational path between the two sides.
- in_ready = (count < DEPTH); at full, in_ready stays 0 even if a pop occurs that cycle; rises the following cycle.
- out_valid = (count ≥ 1); payload at the output is the head entry, stable while out_valid && !out_ready.
- Channels are fully independent; no ordering enforced between AW and W, nor between read and write paths.
- Elaboration check: $fatal if interface widths differ from parameters or any DEPTH < 0.

## Timing
- Reset (rstn low, asynchronous): all counts and pointers 0; every out_valid = 0; every FIFO in_ready = 0. Storage arrays not reset.
- First rising edge with rstn high: in_ready → 1 for all FIFO channels.
- Latency: push at edge N → out_valid high after edge N (visible in cycle N+1); 1 cycle per buffered channel.
- Throughput: DEPTH = 1 sustains one beat per 2 cycles; DEPTH ≥ 2 sustains one beat per cycle with continuous out_ready.
- Full + simultaneous pop: pop accepted, push refused; count DEPTH-1 next cycle.
- Empty + simultaneous push: push accepted; out_valid 0 that cycle (no fall-through).
- Reset asserted mid-transfer: in-flight entries discarded, outputs low immediately (asynchronous); no partial beat emitted after release.

## Structure
- prot_t and resp_t come from axi_common; no new package types. Per-channel payload widths are localparams inside the block.
- One sub-module: axi_fifo #(WIDTH, DEPTH), generic valid/ready FIFO with the above rules and DEPTH = 0 pass-through; instantiated five times.

## Test plan
- Reset release, all DEPTH = 2: all out_valid = 0 throughout reset; all slave/master in_ready = 1 on cycle after first edge with rstn high.
- AW_DEPTH = 2, push addr 0x1000/0x2000/0x3000 back-to-back with master.aw_ready = 0 → two accepted, aw_ready 0 at third; release ready → 0x1000, 0x2000, then 0x3000 in order, prot preserved.
- W_DEPTH = 3, continuous valid and ready, 16 beats data = i, strb = 0xFF → 16 beats out in order at 1 beat/cycle after 1-cycle latency.
- R_DEPTH = 1, continuous traffic → r_valid toggles, one beat every 2 cycles, r_resp = OKAY/SLVERR pattern preserved.
- B_DEPTH = 0: b_valid/b_ready/b_resp = DECERR propagate same cycle, zero latency.
- Assert rstn low with AR FIFO holding 2 entries → slave.ar_ready, master.ar_valid drop to 0 immediately; after release no stale AR beat appears.
